shift595_scan: RTL

Parametrised multiplexed 7-segment display scanner driving a daisy-chained pair of 74HC595 shift registers (segment byte plus digit-select byte) over a 3-wire serial link. It takes a packed hex value with per-digit decimal-point and blank masks from the core and refreshes 1 to 8 digits continuously. It adds tear-free double-buffered updates, optional leading-zero blanking, selectable segment and digit polarity, and a frame-complete pulse.

---
 rtl/shift595_scan.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/shift595_scan.sv
// Multiplexed 7-segment scanner feeding a chained pair of 74HC595s (segment byte, then select byte).
// Frames are double-buffered so a display update never tears mid-scan.
module shift595_scan #(
   parameter int unsigned NDIGITS        = 4,
   parameter int unsigned DIVIDER        = 1024,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned DIG_ACTIVE_LOW = 0,
   parameter int unsigned LZ_BLANK       = 0
) (
   input  logic                   SYSCLK,
   input  logic                   RSTn,
   input  logic [4*NDIGITS-1:0]   VALUE,
   input  logic [NDIGITS-1:0]     DP,
   input  logic [NDIGITS-1:0]     BLANK,
   input  logic                   LOAD,
   output logic                   SCK,
   output logic                   LATCH,
   output logic                   DO,
   output logic                   FRAME
);

   localparam int unsigned DIV_W = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
   localparam int unsigned DIG_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int unsigned VAL_W = 4 * NDIGITS;

   typedef enum logic [1:0] {SLO, SHI, LAT} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_cnt;
   logic [3:0]         bit_q, bit_d;
   logic [DIG_W-1:0]   digit_q, digit_d;
   logic               sck_d, latch_d, do_d, frame_d;
   logic               tick, copy;

   logic [VAL_W-1:0]   pend_value, act_value, new_value, src_value;
   logic [NDIGITS-1:0] pend_dp, act_dp, new_dp, src_dp;
   logic [NDIGITS-1:0] pend_blank, act_blank, new_blank, src_blank;

   logic [3:0]         nib;
   logic               dp_bit, blank_bit, lz_hit, zero_run;
   logic [6:0]         glyph;
   logic [7:0]         seg_raw, seg, sel_raw, sel;
   logic [15:0]        word;

   function automatic logic [6:0] hex_font(input logic [3:0] n);
      case (n)
         4'h0: hex_font = 7'h3F;
         4'h1: hex_font = 7'h06;
         4'h2: hex_font = 7'h5B;
         4'h3: hex_font = 7'h4F;
         4'h4: hex_font = 7'h66;
         4'h5: hex_font = 7'h6D;
         4'h6: hex_font = 7'h7D;
         4'h7: hex_font = 7'h07;
         4'h8: hex_font = 7'h7F;
         4'h9: hex_font = 7'h6F;
         4'hA: hex_font = 7'h77;
         4'hB: hex_font = 7'h7C;
         4'hC: hex_font = 7'h39;
         4'hD: hex_font = 7'h5E;
         4'hE: hex_font = 7'h79;
         default: hex_font = 7'h71;
      endcase
   endfunction

   assign tick = (div_cnt == DIV_W'(DIVIDER - 1));
   assign copy = tick && (state_q == SLO) && (bit_q == 4'd0) && (digit_q == '0);

   // A LOAD coinciding with the copy tick goes straight into the new frame
   assign new_value = LOAD ? VALUE : pend_value;
   assign new_dp    = LOAD ? DP    : pend_dp;
   assign new_blank = LOAD ? BLANK : pend_blank;
   assign src_value = copy ? new_value : act_value;
   assign src_dp    = copy ? new_dp    : act_dp;
   assign src_blank = copy ? new_blank : act_blank;

   always_ff @(posedge SYSCLK) begin
      if (!RSTn) div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else div_cnt <= div_cnt + DIV_W'(1);
   end

   always_ff @(posedge SYSCLK) begin
      if (!RSTn) begin
         pend_value <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         act_value  <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
      end else begin
         if (LOAD) begin
            pend_value <= VALUE;
            pend_dp    <= DP;
            pend_blank <= BLANK;
         end
         if (copy) begin
            act_value <= new_value;
            act_dp    <= new_dp;
            act_blank <= new_blank;
         end
      end
   end

   // Current digit word; zero_run tracks "this and every higher nibble is zero"
   always_comb begin
      nib       = 4'h0;
      dp_bit    = 1'b0;
      blank_bit = 1'b0;
      lz_hit    = 1'b0;
      zero_run  = 1'b1;
      for (int d = int'(NDIGITS) - 1; d >= 0; d--) begin
         zero_run = zero_run && (src_value[4*d +: 4] == 4'h0);
         if (digit_q == DIG_W'(d)) begin
            nib       = src_value[4*d +: 4];
            dp_bit    = src_dp[d];
            blank_bit = src_blank[d];
            lz_hit    = zero_run && (d != 0);
         end
      end
      glyph   = (blank_bit || ((LZ_BLANK != 0) && lz_hit)) ? 7'h00 : hex_font(nib);
      seg_raw = {dp_bit && !blank_bit, glyph};
      sel_raw = 8'(1) << digit_q;
      seg     = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      sel     = (DIG_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
      word    = {seg, sel};
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      digit_d = digit_q;
      sck_d   = SCK;
      latch_d = LATCH;
      do_d    = DO;
      frame_d = 1'b0;
      if (tick) begin
         case (state_q)
            SLO: begin
               sck_d   = 1'b0;
               latch_d = 1'b0;
               do_d    = word[4'd15 - bit_q];
               state_d = SHI;
            end
            SHI: begin
               sck_d = 1'b1;
               if (bit_q == 4'd15) begin
                  state_d = LAT;
               end else begin
                  bit_d   = bit_q + 4'd1;
                  state_d = SLO;
               end
            end
            LAT: begin
               sck_d   = 1'b0;
               latch_d = 1'b1;
               bit_d   = 4'd0;
               state_d = SLO;
               if (digit_q == DIG_W'(NDIGITS - 1)) begin
                  digit_d = '0;
                  frame_d = 1'b1;
               end else begin
                  digit_d = digit_q + DIG_W'(1);
               end
            end
            default: state_d = SLO;
         endcase
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (!RSTn) begin
         state_q <= SLO;
         bit_q   <= 4'd0;
         digit_q <= '0;
         SCK     <= 1'b0;
         LATCH   <= 1'b0;
         DO      <= 1'b0;
         FRAME   <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         digit_q <= digit_d;
         SCK     <= sck_d;
         LATCH   <= latch_d;
         DO      <= do_d;
         FRAME   <= frame_d;
      end
   end

endmodule
